// File: rtl/dff_deserializer_if.sv
// Bit-stream in / word-out bundle for dff_deserializer.
// master drives the flip-flop outputs and handshake; slave is the deserializer.
interface dff_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             Q;
  logic             nQ;
  logic             en;
  logic             rdy;
  logic [WIDTH-1:0] data;
  logic             vld;
  logic             err;
  logic             ovf;

  modport master (
    output Q, nQ, en, rdy,
    input  data, vld, err, ovf
  );

  modport slave (
    input  Q, nQ, en, rdy,
    output data, vld, err, ovf
  );
endinterface

// File: rtl/dff_deserializer.sv
// Serial-to-parallel capture of a dff's Q/nQ stream into WIDTH-bit words (MSB first),
// with a single registered output slot, sticky invalid-sample and dropped-word flags.
module dff_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic              C,
  input  logic              nR,
  dff_deserializer_if.slave bus
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] data_r, data_n, word;
  logic             vld_r, vld_n;
  logic             err_r, err_n;
  logic             ovf_r, ovf_n;
  logic             valid, done;

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      data_r <= '0;
      vld_r  <= 1'b0;
      err_r  <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state  <= state_n;
      sreg   <= sreg_n;
      cnt    <= cnt_n;
      data_r <= data_n;
      vld_r  <= vld_n;
      err_r  <= err_n;
      ovf_r  <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    data_n  = data_r;
    vld_n   = vld_r;
    err_n   = err_r;
    ovf_n   = ovf_r;
    valid   = bus.Q ^ bus.nQ;
    word    = {sreg[WIDTH-2:0], bus.Q};
    done    = bus.en && valid && (cnt == LAST);

    case (state)
      IDLE:    if (bus.en) state_n = SHIFT;
      SHIFT:   if (!bus.en) begin
                 // dropping en abandons the partial word
                 state_n = IDLE;
                 cnt_n   = '0;
                 sreg_n  = '0;
               end
      default: state_n = IDLE;
    endcase

    // a non-complementary sample is skipped, not zero-filled
    if (bus.en) begin
      if (valid) begin
        sreg_n = word;
        cnt_n  = done ? '0 : cnt + CW'(1);
      end else begin
        err_n = 1'b1;
      end
    end

    // completion outranks plain dequeue so words can go back-to-back
    if (done) begin
      if (!vld_r || bus.rdy) begin
        data_n = word;
        vld_n  = 1'b1;
      end else begin
        ovf_n = 1'b1;
      end
    end else if (vld_r && bus.rdy) begin
      vld_n = 1'b0;
    end
  end

  assign bus.data = data_r;
  assign bus.vld  = vld_r;
  assign bus.err  = err_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_dff_deserializer.sv
// Bench for dff_deserializer: constant vector table, directed multi-cycle sequences,
// then random traffic scored against a bit-queue reference model.
module tb_dff_deserializer;
  localparam int W = 8;

  logic C = 1'b0;
  logic nR;
  dff_deserializer_if #(.WIDTH(W)) bus();
  dff_deserializer #(.WIDTH(W)) dut (.C(C), .nR(nR), .bus(bus));

  always #5 C = ~C;

  typedef struct {
    logic         q, nq, en, rdy;
    logic         vld;
    logic [W-1:0] data;
    logic         err, ovf;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  // reference model: received bits of the current word, plus output slot and flags
  int           mbits[$];
  logic         m_vld, m_err, m_ovf;
  logic [W-1:0] m_data;

  function automatic void add(logic q, logic nq, logic en, logic rdy,
                              logic vld, logic [W-1:0] data, logic err, logic ovf);
    vec_t v;
    v.q = q; v.nq = nq; v.en = en; v.rdy = rdy;
    v.vld = vld; v.data = data; v.err = err; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbits.delete();
    m_vld = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_data = '0;
  endtask

  task automatic model_edge(logic q, logic nq, logic e, logic r);
    bit done = 0;
    int w = 0;
    if (!e) mbits.delete();
    else if (q != nq) begin
      mbits.push_back(int'(q));
      if (mbits.size() == W) begin
        foreach (mbits[i]) w = (w << 1) | mbits[i];
        mbits.delete();
        done = 1;
      end
    end else m_err = 1'b1;
    if (done) begin
      if (!m_vld || r) begin m_data = W'(w); m_vld = 1'b1; end
      else m_ovf = 1'b1;
    end else if (m_vld && r) m_vld = 1'b0;
  endtask

  task automatic apply(logic q, logic nq, logic e, logic r);
    bus.Q = q; bus.nQ = nq; bus.en = e; bus.rdy = r;
    @(posedge C);
    model_edge(q, nq, e, r);
    #1;
  endtask

  task automatic send(logic [W-1:0] w, logic r);
    for (int i = W - 1; i >= 0; i--) apply(w[i], ~w[i], 1'b1, r);
  endtask

  task automatic check_model(string tag);
    chk({tag, " vld"},  bus.vld,  m_vld);
    chk({tag, " data"}, bus.data, m_data);
    chk({tag, " err"},  bus.err,  m_err);
    chk({tag, " ovf"},  bus.ovf,  m_ovf);
  endtask

  // pulse nR between edges; optionally check outputs cleared while it is low
  task automatic pulse_reset(bit check);
    nR = 1'b0;
    model_reset();
    #1;
    if (check) begin
      chk("async rst vld",  bus.vld,  0);
      chk("async rst data", bus.data, 0);
      chk("async rst err",  bus.err,  0);
      chk("async rst ovf",  bus.ovf,  0);
    end
    #1;
    nR = 1'b1;
  endtask

  initial begin
    logic [W-1:0] pat;
    logic         q, nq, e, r;

    bus.Q = 1'b0; bus.nQ = 1'b1; bus.en = 1'b0; bus.rdy = 1'b0;
    nR = 1'b0;
    model_reset();

    // basic capture 0xB2, then one idle edge dequeues it
    pat = 8'hB2;
    for (int i = W - 1; i >= 0; i--)
      add(pat[i], ~pat[i], 1, 1, i == 0, (i == 0) ? 8'hB2 : 8'h00, 0, 0);
    add(0, 1, 0, 1, 0, 8'hB2, 0, 0);
    // 0x96 with an invalid sample on the 3rd edge
    add(1, 0, 1, 1, 0, 8'hB2, 0, 0);
    add(0, 1, 1, 1, 0, 8'hB2, 0, 0);
    add(1, 1, 1, 1, 0, 8'hB2, 1, 0);
    add(0, 1, 1, 1, 0, 8'hB2, 1, 0);
    add(1, 0, 1, 1, 0, 8'hB2, 1, 0);
    add(0, 1, 1, 1, 0, 8'hB2, 1, 0);
    add(1, 0, 1, 1, 0, 8'hB2, 1, 0);
    add(1, 0, 1, 1, 0, 8'hB2, 1, 0);
    add(0, 1, 1, 1, 1, 8'h96, 1, 0);
    add(0, 1, 0, 1, 0, 8'h96, 1, 0);
    // 5 samples, en low for 2 edges, then 0x5A
    for (int i = 0; i < 5; i++) add(1, 0, 1, 1, 0, 8'h96, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 1, 0, 1, 0, 8'h96, 1, 0);
    pat = 8'h5A;
    for (int i = W - 1; i >= 0; i--)
      add(pat[i], ~pat[i], 1, 1, i == 0, (i == 0) ? 8'h5A : 8'h96, 1, 0);

    #12;
    chk("reset vld",  bus.vld,  0);
    chk("reset data", bus.data, 0);
    chk("reset err",  bus.err,  0);
    chk("reset ovf",  bus.ovf,  0);
    @(posedge C); #1;
    nR = 1'b1;

    foreach (tbl[k]) begin
      apply(tbl[k].q, tbl[k].nq, tbl[k].en, tbl[k].rdy);
      chk($sformatf("tbl%0d vld", k),  bus.vld,  tbl[k].vld);
      chk($sformatf("tbl%0d data", k), bus.data, tbl[k].data);
      chk($sformatf("tbl%0d err", k),  bus.err,  tbl[k].err);
      chk($sformatf("tbl%0d ovf", k),  bus.ovf,  tbl[k].ovf);
    end

    // backpressure: second word dropped, first held
    pulse_reset(0);
    send(8'hA5, 1'b0);
    chk("bp first vld",  bus.vld,  1);
    chk("bp first data", bus.data, 8'hA5);
    chk("bp first ovf",  bus.ovf,  0);
    pat = 8'h3C;
    for (int i = W - 1; i >= 0; i--) begin
      apply(pat[i], ~pat[i], 1'b1, 1'b0);
      chk("bp hold data", bus.data, 8'hA5);
    end
    chk("bp ovf", bus.ovf, 1);
    chk("bp vld", bus.vld, 1);
    apply(1'b0, 1'b1, 1'b0, 1'b1);
    chk("bp drain vld", bus.vld, 0);

    // back-to-back: completion and dequeue on the same edge keep vld high
    pulse_reset(0);
    send(8'h01, 1'b1);
    chk("b2b first vld",  bus.vld,  1);
    chk("b2b first data", bus.data, 8'h01);
    pat = 8'hFF;
    for (int i = W - 1; i >= 0; i--) begin
      apply(1'b1, 1'b0, 1'b1, i == 0);
      chk("b2b vld", bus.vld, 1);
      chk("b2b data", bus.data, (i == 0) ? 8'hFF : 8'h01);
    end
    chk("b2b ovf", bus.ovf, 0);
    apply(1'b0, 1'b1, 1'b0, 1'b1);
    chk("b2b drain vld", bus.vld, 0);

    // async reset mid-word with a held word and err set
    pulse_reset(0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    send(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre-rst vld", bus.vld, 1);
    pulse_reset(1);
    pat = 8'h3C;
    for (int i = W - 1; i >= 0; i--) begin
      apply(pat[i], ~pat[i], 1'b1, 1'b1);
      chk("post-rst vld", bus.vld, i == 0);
    end
    chk("post-rst data", bus.data, 8'h3C);
    chk("post-rst err",  bus.err,  0);

    // random traffic against the model
    pulse_reset(0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) pulse_reset(0);
      q  = 1'($urandom_range(1));
      nq = ($urandom_range(9) == 0) ? q : ~q;
      e  = ($urandom_range(9) != 0);
      r  = 1'($urandom_range(1));
      apply(q, nq, e, r);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
